// File: rtl/port_skid_pkg.sv
// Shared types and constants for the per-channel skid buffer.
package port_skid_pkg;

    // Channel occupancy states; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skidState_t;

    localparam logic [1:0] CountEmpty = 2'd0;
    localparam logic [1:0] CountOne   = 2'd1;
    localparam logic [1:0] CountFull  = 2'd2;

    // Map a channel state to its occupancy count.
    function automatic logic [1:0] stateCount(input skidState_t s);
        logic [1:0] c;
        c = CountEmpty;
        unique case (s)
            StEmpty: c = CountEmpty;
            StOne:   c = CountOne;
            StFull:  c = CountFull;
            default: c = CountEmpty;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/port_skid_chan.sv
// One channel of the skid buffer: main/skid registers, registered handshakes
// and an optional upstream stability checker.
module port_skid_chan #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CHECK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    output logic             inReady,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    input  logic             outReady,
    output logic [1:0]       count,
    output logic             err
);
    import port_skid_pkg::*;

    skidState_t       stateQ, stateD;
    logic             inReadyQ, inReadyD;
    logic             outValidQ, outValidD;
    logic [WIDTH-1:0] mainQ, skidQ;
    logic             inXfer, outXfer;
    logic             loadMainIn, loadMainSkid, loadSkid;

    assign inXfer  = inValid & inReadyQ;
    assign outXfer = outValidQ & outReady;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StEmpty;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StEmpty: begin
                if (inXfer) stateD = StOne;
            end
            StOne: begin
                if (inXfer && !outXfer)      stateD = StFull;
                else if (!inXfer && outXfer) stateD = StEmpty;
            end
            StFull: begin
                if (outXfer) stateD = StOne;
            end
            default: stateD = StEmpty;
        endcase
    end

    // Datapath load enables and next handshake values
    always_comb begin
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        unique case (stateQ)
            StEmpty: loadMainIn = inXfer;
            StOne: begin
                loadMainIn = inXfer & outXfer;
                loadSkid   = inXfer & ~outXfer;
            end
            StFull:  loadMainSkid = outXfer;
            default: ;
        endcase
        // Handshakes are registered, so they look at the state being entered.
        inReadyD  = (stateD != StFull);
        outValidD = (stateD != StEmpty);
    end

    // Data and handshake registers; in_ready stays low through the release edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ     <= '0;
            skidQ     <= '0;
            inReadyQ  <= 1'b0;
            outValidQ <= 1'b0;
        end else begin
            if (loadMainIn)        mainQ <= inData;
            else if (loadMainSkid) mainQ <= skidQ;
            if (loadSkid)          skidQ <= inData;
            inReadyQ  <= inReadyD;
            outValidQ <= outValidD;
        end
    end

    assign inReady  = inReadyQ;
    assign outValid = outValidQ;
    assign outData  = mainQ;
    assign count    = stateCount(stateQ);

    if (ERR_CHECK != 0) begin : gen_err
        logic             stallQ;
        logic [WIDTH-1:0] heldQ;
        logic             errQ, errD;

        // Flag a stalled offer that is withdrawn or altered on the next cycle
        always_comb begin
            errD = errQ | (stallQ & (~inValid | (inData != heldQ)));
        end

        // Remember last cycle's stall and data; error flag is sticky
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stallQ <= 1'b0;
                heldQ  <= '0;
                errQ   <= 1'b0;
            end else begin
                stallQ <= inValid & ~inReadyQ;
                heldQ  <= inData;
                errQ   <= errD;
            end
        end

        assign err = errQ;
    end else begin : gen_no_err
        assign err = 1'b0;
    end

endmodule

// File: rtl/port_skid_buffer.sv
// Multi-channel skid buffer: NUM_CH independent two-entry channels.
module port_skid_buffer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ERR_CHECK = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*2-1:0]     count,
    output logic [NUM_CH-1:0]       err
);
    import port_skid_pkg::*;

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        port_skid_chan #(
            .WIDTH     (WIDTH),
            .ERR_CHECK (ERR_CHECK)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .inValid  (in_valid[c]),
            .inData   (in_data[c*WIDTH +: WIDTH]),
            .inReady  (in_ready[c]),
            .outValid (out_valid[c]),
            .outData  (out_data[c*WIDTH +: WIDTH]),
            .outReady (out_ready[c]),
            .count    (count[c*2 +: 2]),
            .err      (err[c])
        );
    end

endmodule

// File: tb/tb_port_skid_buffer.sv
// Directed bench for port_skid_buffer (WIDTH=8, NUM_CH=2).
module tb_port_skid_buffer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_ready;
    logic [3:0]  count;
    logic [1:0]  err;

    int compared;
    int mismatched;

    typedef struct {
        logic [1:0]  iv;
        logic [15:0] id;
        logic [1:0]  ordy;
        logic [1:0]  ir;
        logic [1:0]  ov;
        logic [15:0] od;
        logic [15:0] odm;
        logic [3:0]  cnt;
        logic [1:0]  er;
    } vec_t;

    vec_t vecs[$];

    port_skid_buffer #(
        .WIDTH     (8),
        .NUM_CH    (2),
        .ERR_CHECK (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic [1:0] iv, input logic [15:0] id,
                                   input logic [1:0] ordy, input logic [1:0] ir,
                                   input logic [1:0] ov, input logic [15:0] od,
                                   input logic [15:0] odm, input logic [3:0] cnt,
                                   input logic [1:0] er);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.ir = ir; v.ov = ov;
        v.od = od; v.odm = odm; v.cnt = cnt; v.er = er;
        vecs.push_back(v);
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;

        // iv, id{ch1,ch0}, ordy | in_ready, out_valid, out_data, data mask, count, err
        // First edge after release: valid held, nothing accepted, in_ready rises
        addVec(2'b01, 16'h0055, 2'b00, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        addVec(2'b01, 16'h0055, 2'b00, 2'b11, 2'b01, 16'h0055, 16'h00FF, 4'b0001, 2'b00);
        // Streaming on ch0
        addVec(2'b01, 16'h0011, 2'b01, 2'b11, 2'b01, 16'h0011, 16'h00FF, 4'b0001, 2'b00);
        addVec(2'b01, 16'h0022, 2'b01, 2'b11, 2'b01, 16'h0022, 16'h00FF, 4'b0001, 2'b00);
        addVec(2'b01, 16'h0033, 2'b01, 2'b11, 2'b01, 16'h0033, 16'h00FF, 4'b0001, 2'b00);
        addVec(2'b00, 16'h0000, 2'b01, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        // Backpressure on ch0
        addVec(2'b01, 16'h00A1, 2'b00, 2'b11, 2'b01, 16'h00A1, 16'h00FF, 4'b0001, 2'b00);
        addVec(2'b01, 16'h00A2, 2'b00, 2'b10, 2'b01, 16'h00A1, 16'h00FF, 4'b0010, 2'b00);
        addVec(2'b00, 16'h0000, 2'b00, 2'b10, 2'b01, 16'h00A1, 16'h00FF, 4'b0010, 2'b00);
        addVec(2'b00, 16'h0000, 2'b01, 2'b11, 2'b01, 16'h00A2, 16'h00FF, 4'b0001, 2'b00);
        addVec(2'b00, 16'h0000, 2'b01, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        // Fill ch1 to FULL
        addVec(2'b10, 16'hB100, 2'b01, 2'b11, 2'b10, 16'hB100, 16'hFF00, 4'b0100, 2'b00);
        addVec(2'b10, 16'hB200, 2'b01, 2'b01, 2'b10, 16'hB100, 16'hFF00, 4'b1000, 2'b00);
        // ch0 streams 0x05..0x0F while ch1 stays FULL
        for (int x = 5; x <= 15; x++) begin
            addVec(2'b01, {8'h00, 8'(x)}, 2'b01, 2'b01, 2'b11, {8'hB1, 8'(x)}, 16'hFFFF,
                   4'b1001, 2'b00);
        end
        addVec(2'b00, 16'h0000, 2'b01, 2'b01, 2'b10, 16'hB100, 16'hFF00, 4'b1000, 2'b00);
        // Drain ch1 in order
        addVec(2'b00, 16'h0000, 2'b10, 2'b11, 2'b10, 16'hB200, 16'hFF00, 4'b0100, 2'b00);
        addVec(2'b00, 16'h0000, 2'b10, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'b0000, 2'b00);
        // Protocol error on ch1: stalled 0x3C changes to 0x3D
        addVec(2'b10, 16'hC100, 2'b00, 2'b11, 2'b10, 16'hC100, 16'hFF00, 4'b0100, 2'b00);
        addVec(2'b10, 16'hC200, 2'b00, 2'b01, 2'b10, 16'hC100, 16'hFF00, 4'b1000, 2'b00);
        addVec(2'b10, 16'h3C00, 2'b00, 2'b01, 2'b10, 16'hC100, 16'hFF00, 4'b1000, 2'b00);
        addVec(2'b10, 16'h3C00, 2'b00, 2'b01, 2'b10, 16'hC100, 16'hFF00, 4'b1000, 2'b00);
        addVec(2'b10, 16'h3D00, 2'b00, 2'b01, 2'b10, 16'hC100, 16'hFF00, 4'b1000, 2'b10);
        addVec(2'b00, 16'h0000, 2'b00, 2'b01, 2'b10, 16'hC100, 16'hFF00, 4'b1000, 2'b10);
        addVec(2'b00, 16'h0000, 2'b10, 2'b11, 2'b10, 16'hC200, 16'hFF00, 4'b0100, 2'b10);
        addVec(2'b00, 16'h0000, 2'b10, 2'b11, 2'b00, 16'h0000, 16'h0000, 4'b0000, 2'b10);

        // Reset held
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset count", 32'(count), 32'h0);
        check("reset err", 32'(err), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].er));
            if (vecs[i].odm != 16'h0000) begin
                check($sformatf("v%0d out_data", i), 32'(out_data & vecs[i].odm),
                      32'(vecs[i].od & vecs[i].odm));
            end
        end

        // Mid-operation reset with ch0 FULL
        in_valid  = 2'b01;
        in_data   = 16'h00D1;
        out_ready = 2'b00;
        @(posedge clk);
        #1;
        in_data = 16'h00D2;
        @(posedge clk);
        #1;
        check("pre-reset count", 32'(count), 32'h2);
        check("pre-reset in_ready", 32'(in_ready), 32'h2);
        in_valid = 2'b00;
        in_data  = 16'h0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset count", 32'(count), 32'h0);
        check("async reset out_valid", 32'(out_valid), 32'h0);
        check("async reset in_ready", 32'(in_ready), 32'h0);
        check("async reset err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        check("in reset count", 32'(count), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'h3);
        check("post-reset out_valid", 32'(out_valid), 32'h0);
        in_valid  = 2'b01;
        in_data   = 16'h0077;
        out_ready = 2'b01;
        @(posedge clk);
        #1;
        check("0x77 out_valid", 32'(out_valid), 32'h1);
        check("0x77 out_data", 32'(out_data[7:0]), 32'h77);
        check("0x77 count", 32'(count), 32'h1);
        in_valid = 2'b00;
        @(posedge clk);
        #1;
        check("0x77 drained out_valid", 32'(out_valid), 32'h0);
        check("0x77 drained count", 32'(count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/port_skid_buffer.md
PORT_SKID_BUFFER -- requirements
Module: port_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal range 1..64).
REQ-002 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent channels (legal range 1..16).
REQ-003 The block SHALL have parameter ERR_CHECK, default 1, meaning 1 enables the input-stability checker and 0 ties err to 0.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, width NUM_CH, meaning per-channel upstream valid.
REQ-007 The block SHALL have port in_data, input, width NUM_CH*WIDTH, meaning packed upstream data, with channel c at bits [c*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_ready, output, width NUM_CH, meaning per-channel upstream ready, driven from a register.
REQ-009 The block SHALL have port out_valid, output, width NUM_CH, meaning per-channel downstream valid, driven from a register.
REQ-010 The block SHALL have port out_data, output, width NUM_CH*WIDTH, meaning per-channel downstream data from the main register, packed as in_data.
REQ-011 The block SHALL have port out_ready, input, width NUM_CH, meaning per-channel downstream ready.
REQ-012 The block SHALL have port count, output, width NUM_CH*2, meaning per-channel occupancy 0..2.
REQ-013 The block SHALL have port err, output, width NUM_CH, meaning a per-channel sticky protocol-violation flag.

Function
REQ-014 Channels SHALL be fully independent; no signal of channel c SHALL affect channel d.
REQ-015 An input transfer SHALL occur when in_valid & in_ready are both high, and an output transfer when out_valid & out_ready are both high, both sampled at the clock edge.
REQ-016 Each channel SHALL implement states EMPTY (count 0), ONE (count 1, main register valid) and FULL (count 2, main and skid registers valid).
REQ-017 In EMPTY, an input transfer SHALL load main and move the channel to ONE.
REQ-018 In ONE, with input and output transfers together, the channel SHALL load main from in_data and stay in ONE.
REQ-019 In ONE, with an input transfer only, the channel SHALL load skid from in_data and move to FULL.
REQ-020 In ONE, with an output transfer only, the channel SHALL move to EMPTY.
REQ-021 In FULL, an output transfer SHALL copy skid to main and move the channel to ONE.
REQ-022 In FULL, no input transfer is possible because in_ready is 0.
REQ-023 in_ready SHALL be 1 exactly when the state is not FULL; out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-024 Latency from an input transfer to out_valid with the same data SHALL be 1 cycle in EMPTY; sustained throughput SHALL be 1 transfer per cycle per channel.
REQ-025 Ordering SHALL be strict FIFO; no datum SHALL be dropped or duplicated.
REQ-026 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-027 When ERR_CHECK=1, err[c] SHALL set on the edge after a cycle in which in_valid[c] was 1 and in_ready[c] was 0, if in_valid[c] is then 0 or in_data[c] has changed.
REQ-028 err[c] SHALL be sticky until reset.
REQ-029 out_data contents in EMPTY are don't-care; the bench SHALL NOT check them.

Reset
REQ-030 Asserting rst_n=0 at any time, including mid-transfer, SHALL immediately force all channels to EMPTY, with count=0, out_valid=0, in_ready=0 and err=0.
REQ-031 Reset SHALL force main and skid registers to 0.
REQ-032 On the first clock edge after rst_n deasserts, in_ready SHALL become 1; no transfer SHALL be accepted during that edge.

Structure
REQ-033 The state enum (EMPTY, ONE, FULL) and the count-encoding constants SHALL live in shared package port_skid_pkg.
REQ-034 The per-channel logic SHALL be sub-module port_skid_chan, parameterised by WIDTH and ERR_CHECK, and instantiated NUM_CH times via generate.

Verification
REQ-035 Reset release: rst_n low, then high -> one edge later in_ready=2'b11, out_valid=0, count=0, err=0.
REQ-036 Streaming: ch0 sends 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data ch0 shows 0x11, 0x22, 0x33 one cycle later, count stays 1, in_ready stays 1.
REQ-037 Backpressure: out_ready[0]=0, send 0xA1 then 0xA2 -> count=2 and in_ready[0]=0; raise out_ready -> 0xA1 then 0xA2 appear in order with no loss.
REQ-038 Independence: ch1 is held FULL while ch0 streams 0x05..0x0F -> ch0 is unaffected and ch1 data is preserved.
REQ-039 Protocol error: ch1 FULL, upstream changes in_data from 0x3C to 0x3D while in_ready=0 -> err[1]=1 and stays 1, and err[0]=0.
REQ-040 Mid-operation reset: ch0 FULL, rst_n pulsed low -> count=0, out_valid=0 immediately; after release, 0x77 flows with 1-cycle latency.
